sap1_control_sequencer: RTL
===========================

Name: sap1_control_sequencer

Overview:
Control sequencer for the SAP-1 datapath (PC, MAR, RAM, IR, A, B, ALU, OUT register). It runs a six-state ring counter (T1..T6) and decodes the IR opcode nibble into a 12-bit active-high control word each cycle. It also handles run/pause gating, a sticky halt on HLT and a completed-instruction counter. It sits between the top-level SAP-1 wrapper (clk, clr, run_prog) and the datapath registers.

Parameters:
CNT_W, 8, width of the instruction counter (saturating)
T_STATES, 6, ring length; fixed at 6, other values unsupported

Ports:
clk  input  1  system clock; all state updates on the rising edge
clr  input  1  synchronous active-high reset
run_prog  input  1  1 = advance sequencer; 0 = pause (state held, ctrl forced 0)
opcode  input  4  IR[7:4] from the datapath; valid from T4 onward
ctrl  output  12  control word: [11]pc_inc [10]pc_en [9]mar_ld [8]ram_en [7]ir_ld [6]ir_en [5]a_ld [4]a_en [3]alu_sub [2]alu_en [1]b_ld [0]out_ld
t_state  output  6  one-hot ring state; bit0 = T1
halted  output  1  sticky halt flag
instr_count  output  CNT_W  number of completed instructions

Behaviour:
- Reset: clk rising edge with clr=1 sets t_state=6'b000001, halted=0, instr_count=0. clr has priority over run_prog and HLT. ctrl is combinational and reads 0 while clr=1.
- Advance: when run_prog=1, halted=0 and clr=0, t_state rotates left one position per clock; T6 wraps to T1.
- Pause: when run_prog=0, t_state, halted and instr_count hold, and ctrl=0. Resuming continues from the held T-state with no lost or repeated state.
- ctrl is a zero-latency combinational decode of (t_state, opcode), gated by run_prog & ~halted & ~clr.
- Fetch, all opcodes: T1 = pc_en, mar_ld. T2 = pc_inc. T3 = ram_en, ir_ld.
- LDA 4'h0: T4 = ir_en, mar_ld. T5 = ram_en, a_ld. T6 = none.
- ADD 4'h1: T4 = ir_en, mar_ld. T5 = ram_en, b_ld. T6 = alu_en, a_ld.
- SUB 4'h2: same as ADD, plus alu_sub in T6.
- OUT 4'hE: T4 = a_en, out_ld. T5 and T6 = none.
- HLT 4'hF: T4 ctrl = 0. On the T4 clock edge, halted<=1 and t_state holds at T4. Only clr leaves halt. instr_count increments once for HLT on that same edge.
- Any other opcode: NOP, T4..T6 ctrl = 0.
- instr_count increments on every T6->T1 edge (and on the HLT edge). It saturates at 2^CNT_W-1 and does not wrap.
- At most one bus driver (pc_en, ram_en, ir_en, a_en, alu_en) is asserted in any cycle; this is an invariant.
- clr mid-instruction abandons the instruction. Next cycle is T1 with no partial count.

Optional Feature:
SAP1_VARIABLE_CYCLE_EN
- Defined: after the last active state the ring returns straight to T1. LDA returns after T5; OUT and NOP return after T4. instr_count increments on that return edge. ADD, SUB and HLT are unchanged.
- Undefined: every instruction takes the fixed 6 states.

Decomposition:
- Package sap1_pkg holds: opcode localparams (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT), control bit indices (CTRL_PC_INC … CTRL_OUT_LD), CTRL_W=12, and one-hot T-state constants T1..T6.
- One sub-module, sap1_ring_counter, contains the one-hot ring with clr, enable and hold/early-wrap inputs. The decode and counter stay in the top module.

Test Plan:
- clr=1 for 2 clocks, then run_prog=1 -> t_state=000001, ctrl=12'h600 (pc_en|mar_ld), instr_count=0.
- opcode=4'h1 (ADD), run 6 clocks -> ctrl sequence 600, 800, 180, 240, 102, 024. Then instr_count=1 and t_state back to T1.
- opcode=4'h2 (SUB) at T6 -> ctrl=12'h02C. opcode=4'hE at T4 -> ctrl=12'h011.
- run_prog dropped at T3 for 5 clocks -> t_state stays 000100 and ctrl=0. After re-raise, next ctrl=12'h180.
- opcode=4'hF reaching T4 -> halted=1 and ctrl=0 for 20 clocks. instr_count +1 exactly once. clr -> halted=0, T1.
- Macro defined, opcode=4'hE -> T1..T4 then T1, a 4-cycle instruction. Without the macro, the same stimulus takes 6 cycles.

Source files
------------

// File: rtl/sap1_control_sequencer_pkg.sv
// Shared definitions for the SAP-1 control sequencer: opcodes, control-word
// bit positions and the one-hot T-state encoding.
package sap1_pkg;

    localparam int CTRL_W = 12;
    localparam int T_W    = 6;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int CTRL_PC_INC  = 11;
    localparam int CTRL_PC_EN   = 10;
    localparam int CTRL_MAR_LD  = 9;
    localparam int CTRL_RAM_EN  = 8;
    localparam int CTRL_IR_LD   = 7;
    localparam int CTRL_IR_EN   = 6;
    localparam int CTRL_A_LD    = 5;
    localparam int CTRL_A_EN    = 4;
    localparam int CTRL_ALU_SUB = 3;
    localparam int CTRL_ALU_EN  = 2;
    localparam int CTRL_B_LD    = 1;
    localparam int CTRL_OUT_LD  = 0;

    // One-hot ring states, bit0 = T1.
    typedef enum logic [T_W-1:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    // Control word with only the given bit set.
    function automatic logic [CTRL_W-1:0] cbit(input int idx);
        return {{(CTRL_W-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/sap1_control_sequencer_if.sv
// Bus between the SAP-1 wrapper/datapath (master) and the control sequencer (slave).
interface sap1_control_sequencer_if #(
    parameter int CNT_W = 8
);
    logic                       run_prog;
    logic [3:0]                 opcode;
    logic [sap1_pkg::CTRL_W-1:0] ctrl;
    logic [sap1_pkg::T_W-1:0]   t_state;
    logic                       halted;
    logic [CNT_W-1:0]           instr_count;

    modport master (
        output run_prog, opcode,
        input  ctrl, t_state, halted, instr_count
    );

    modport slave (
        input  run_prog, opcode,
        output ctrl, t_state, halted, instr_count
    );
endinterface

// File: rtl/sap1_control_sequencer_ring.sv
// One-hot T1..T6 ring counter with synchronous clear, advance enable,
// hold (used to park on T4 during HLT) and early wrap back to T1.
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic           clk,
    input  logic           clr,
    input  logic           en,
    input  logic           hold,
    input  logic           wrap,
    output logic [T_W-1:0] t_state
);

    t_state_e state_q;
    t_state_e state_d;

    // Next ring position: rotate left, wrap early, or hold.
    always_comb begin
        state_d = state_q;
        if (en && !hold) begin
            if (wrap) begin
                state_d = T1;
            end else begin
                case (state_q)
                    T1:      state_d = T2;
                    T2:      state_d = T3;
                    T3:      state_d = T4;
                    T4:      state_d = T5;
                    T5:      state_d = T6;
                    T6:      state_d = T1;
                    default: state_d = T1;
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // Ring state register with synchronous clear to T1.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= T1;
        end else begin
            state_q <= state_d;
        end
    end

    assign t_state = state_q;

endmodule

// File: rtl/sap1_control_sequencer.sv
// SAP-1 control sequencer: drives the T-state ring, decodes (T-state, opcode)
// into the 12-bit control word, tracks sticky halt and counts completed
// instructions (saturating).
// Optional build macro SAP1_VARIABLE_CYCLE_EN: LDA finishes after T5 and
// OUT/NOP after T4, returning straight to T1.
module sap1_control_sequencer
    import sap1_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int T_STATES = 6
) (
    input  logic                     clk,
    input  logic                     clr,
    sap1_control_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [T_STATES-1:0] t_state_s;
    logic                adv_s;
    logic                hlt_edge_s;
    logic                wrap_s;
    logic                done_s;
    logic                ring_en_s;
    logic [CTRL_W-1:0]   ctrl_s;

    logic                halted_q;
    logic                halted_d;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;

    assign ring_en_s = bus.run_prog & ~halted_q;

    sap1_ring_counter u_ring (
        .clk     (clk),
        .clr     (clr),
        .en      (ring_en_s),
        .hold    (hlt_edge_s),
        .wrap    (wrap_s),
        .t_state (t_state_s)
    );

    // Sequencing events: advance, HLT park, early return, instruction done.
    always_comb begin
        adv_s      = bus.run_prog & ~halted_q & ~clr;
        hlt_edge_s = adv_s & (t_state_s == T4) & (bus.opcode == OP_HLT);
        wrap_s     = 1'b0;
`ifdef SAP1_VARIABLE_CYCLE_EN
        case (bus.opcode)
            OP_LDA:                 wrap_s = adv_s & (t_state_s == T5);
            OP_ADD, OP_SUB, OP_HLT: wrap_s = 1'b0;
            default:                wrap_s = adv_s & (t_state_s == T4);
        endcase
`else
        wrap_s     = 1'b0;
`endif
        done_s     = hlt_edge_s | wrap_s | (adv_s & (t_state_s == T6));
    end

    // Next halt flag and saturating instruction count.
    always_comb begin
        halted_d = halted_q | hlt_edge_s;
        if (done_s && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Halt flag and instruction counter registers, cleared by clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            halted_q <= 1'b0;
            count_q  <= {CNT_W{1'b0}};
        end else begin
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    // Control word decode; forced to zero unless actively running.
    always_comb begin
        ctrl_s = {CTRL_W{1'b0}};
        if (adv_s) begin
            case (t_state_s)
                T1: ctrl_s = cbit(CTRL_PC_EN) | cbit(CTRL_MAR_LD);
                T2: ctrl_s = cbit(CTRL_PC_INC);
                T3: ctrl_s = cbit(CTRL_RAM_EN) | cbit(CTRL_IR_LD);
                T4: begin
                    case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB: ctrl_s = cbit(CTRL_IR_EN) | cbit(CTRL_MAR_LD);
                        OP_OUT:                 ctrl_s = cbit(CTRL_A_EN) | cbit(CTRL_OUT_LD);
                        default:                ctrl_s = {CTRL_W{1'b0}};
                    endcase
                end
                T5: begin
                    case (bus.opcode)
                        OP_LDA:         ctrl_s = cbit(CTRL_RAM_EN) | cbit(CTRL_A_LD);
                        OP_ADD, OP_SUB: ctrl_s = cbit(CTRL_RAM_EN) | cbit(CTRL_B_LD);
                        default:        ctrl_s = {CTRL_W{1'b0}};
                    endcase
                end
                T6: begin
                    case (bus.opcode)
                        OP_ADD:  ctrl_s = cbit(CTRL_ALU_EN) | cbit(CTRL_A_LD);
                        OP_SUB:  ctrl_s = cbit(CTRL_ALU_EN) | cbit(CTRL_A_LD) | cbit(CTRL_ALU_SUB);
                        default: ctrl_s = {CTRL_W{1'b0}};
                    endcase
                end
                default: ctrl_s = {CTRL_W{1'b0}};
            endcase
        end else begin
            ctrl_s = {CTRL_W{1'b0}};
        end
    end

    assign bus.ctrl        = ctrl_s;
    assign bus.t_state     = t_state_s;
    assign bus.halted      = halted_q;
    assign bus.instr_count = count_q;

endmodule
